bp_table_ctrl: RTL and testbench

Controller for a direct-mapped table of 1-bit branch predictors (taken = 1, not taken = 0) that a single fetch-side requester reads and a single resolve-side requester writes. It owns a single-ported predictor table and arbitrates each cycle between a lookup and an update, with anti-starvation for lookups. It walks the table to a known value after reset or flush, and optionally keeps prediction statistics. It sits between the fetch stage and the branch-resolve stage.

---
 rtl/bp_pkg.sv | 32 +++
 rtl/bp_table.sv | 48 ++++
 rtl/bp_table_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_bp_table_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch-predictor table controller:
//   - bp_state_e : controller state (init walk / normal run)
//   - TAKEN / NOT_TAKEN : 1-bit prediction encodings
//   - pc_to_idx  : PC -> table index extraction (pc[idx_w+1:2])
// ---------------------------------------------------------------------------
package bp_pkg;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } bp_state_e;

   localparam logic TAKEN     = 1'b1;
   localparam logic NOT_TAKEN = 1'b0;

   // PCs are zero-extended to this width before index extraction so one
   // function serves every PC_W up to 64 bits.
   localparam int unsigned PC_EXT_W = 64;

   // Word-aligned PCs: drop the two byte-offset bits, keep idx_w bits.
   function automatic logic [PC_EXT_W-1:0] pc_to_idx(
      input logic [PC_EXT_W-1:0] pc,
      input int unsigned         idx_w
   );
      logic [PC_EXT_W-1:0] mask;
      mask = (64'd1 << idx_w) - 64'd1;
      return (pc >> 2) & mask;
   endfunction

endpackage

// File: rtl/bp_table.sv
// ---------------------------------------------------------------------------
// bp_table
// 2^IDX_W x 1-bit single-ported predictor storage with synchronous read.
// All sequencing (init walk, arbitration) is owned by the controller.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset (read register only)
//   i_addr       : entry index for read or write
//   i_we, i_wdata: write enable and write data
//   i_re         : read enable; o_rdata updates only when asserted
//   o_rdata      : registered read data, holds when i_re is low
// ---------------------------------------------------------------------------
module bp_table
   import bp_pkg::*;
#(
   parameter int IDX_W = 6
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [IDX_W-1:0] i_addr,
   input  logic             i_we,
   input  logic             i_wdata,
   input  logic             i_re,
   output logic             o_rdata
);

   // Storage is not reset: the controller's init walk defines its contents.
   logic [(1 << IDX_W)-1:0] r_mem;
   logic                    r_rdata;

   // Storage write port.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   // Synchronous read register; holds its value between reads.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rdata <= NOT_TAKEN;
      end else if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/bp_table_ctrl.sv
// ---------------------------------------------------------------------------
// bp_table_ctrl
// Controller for a direct-mapped table of 1-bit branch predictors. Walks the
// table to INIT_PRED after reset/flush, then arbitrates one access per cycle
// between a fetch-side lookup and a resolve-side update. Updates win by
// default; a lookup blocked by updates for 2 consecutive cycles gets priority.
// Optional feature macro: BP_STATS_EN (adds o_stat_lookups / o_stat_mispred).
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_en                  : global enable, 0 freezes the controller
//   i_flush               : one-cycle pulse, restarts the init walk
//   i_lookup_valid/_pc    : lookup request; o_lookup_ready = accepted (comb)
//   o_pred_valid/_taken   : prediction, one cycle after an accepted lookup
//   i_upd_valid/_pc       : update request; o_upd_ready = accepted (comb)
//   i_upd_result          : resolved direction written to the entry
//   i_upd_pred            : prediction that was used (statistics only)
//   o_busy                : init walk in progress
//   o_stat_lookups/_mispred : saturating counters (BP_STATS_EN only)
// ---------------------------------------------------------------------------
module bp_table_ctrl
   import bp_pkg::*;
#(
   parameter int   IDX_W     = 6,
   parameter int   PC_W      = 32,
   parameter logic INIT_PRED = TAKEN
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_en,
   input  logic            i_flush,
   input  logic            i_lookup_valid,
   input  logic [PC_W-1:0] i_lookup_pc,
   output logic            o_lookup_ready,
   output logic            o_pred_valid,
   output logic            o_pred_taken,
   input  logic            i_upd_valid,
   input  logic [PC_W-1:0] i_upd_pc,
   input  logic            i_upd_result,
   input  logic            i_upd_pred,
   output logic            o_upd_ready,
   output logic            o_busy
`ifdef BP_STATS_EN
   ,
   output logic [31:0]     o_stat_lookups,
   output logic [31:0]     o_stat_mispred
`endif
);

   bp_state_e          r_state;
   bp_state_e          w_state_nxt;
   logic [IDX_W-1:0]   r_walk_cnt;
   logic               r_starve;
   logic               r_blk_seen;   // one blocked cycle already seen
   logic               r_pred_valid;

   logic               w_busy;
   logic               w_acc;
   logic               w_walk_en;
   logic               w_walk_last;
   logic               w_lookup_ready;
   logic               w_upd_ready;
   logic               w_lk_acc;
   logic               w_up_acc;

   logic [63:0]        w_lk_idx_full;
   logic [63:0]        w_up_idx_full;
   logic [IDX_W-1:0]   w_lk_idx;
   logic [IDX_W-1:0]   w_up_idx;
   logic [IDX_W-1:0]   w_tbl_addr;
   logic               w_tbl_we;
   logic               w_tbl_wdata;
   logic               w_tbl_rdata;
   logic               w_unused_idx_bits;

   assign w_lk_idx_full = pc_to_idx(64'(i_lookup_pc), IDX_W);
   assign w_up_idx_full = pc_to_idx(64'(i_upd_pc), IDX_W);
   assign w_lk_idx      = w_lk_idx_full[IDX_W-1:0];
   assign w_up_idx      = w_up_idx_full[IDX_W-1:0];
   assign w_unused_idx_bits = ^{w_lk_idx_full[63:IDX_W], w_up_idx_full[63:IDX_W]};

   assign w_walk_last = (r_walk_cnt == {IDX_W{1'b1}});

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic; flush from any state restarts the walk.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_INIT: begin
            if (i_flush) begin
               w_state_nxt = ST_INIT;
            end else if (w_walk_en && w_walk_last) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_INIT;
            end
         end
         ST_RUN: begin
            if (i_flush) begin
               w_state_nxt = ST_INIT;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         default: w_state_nxt = ST_INIT;
      endcase
   end

   // FSM outputs: walk step enable, access permission, busy flag.
   always_comb begin
      w_busy    = 1'b1;
      w_acc     = 1'b0;
      w_walk_en = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_busy    = 1'b1;
            w_acc     = 1'b0;
            w_walk_en = i_en & ~i_flush;
         end
         ST_RUN: begin
            w_busy    = 1'b0;
            w_acc     = i_en & ~i_flush;
            w_walk_en = 1'b0;
         end
         default: begin
            w_busy    = 1'b1;
            w_acc     = 1'b0;
            w_walk_en = 1'b0;
         end
      endcase
   end

   // Arbitration: updates win unless the lookup side is starving.
   assign w_upd_ready    = w_acc & ~(i_lookup_valid & r_starve);
   assign w_lookup_ready = w_acc & ~(i_upd_valid & ~r_starve);
   assign w_lk_acc       = i_lookup_valid & w_lookup_ready;
   assign w_up_acc       = i_upd_valid & w_upd_ready;

   // Init walk counter; wraps to 0 after the last entry.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_walk_cnt <= {IDX_W{1'b0}};
      end else if (w_walk_en) begin
         r_walk_cnt <= r_walk_cnt + {{(IDX_W-1){1'b0}}, 1'b1};
      end
   end

   // Starvation tracking. Only cycles where the table was usable but an
   // update took it count as blocked; disabled or init cycles hold state.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_starve   <= 1'b0;
         r_blk_seen <= 1'b0;
      end else if (w_lk_acc) begin
         r_starve   <= 1'b0;
         r_blk_seen <= 1'b0;
      end else if (w_acc && i_lookup_valid) begin
         if (r_blk_seen) begin
            r_starve <= 1'b1;
         end
         r_blk_seen <= 1'b1;
      end else if (i_en && !i_lookup_valid) begin
         r_blk_seen <= 1'b0;
      end
   end

   // Single table port: walk write, update write, or lookup read.
   always_comb begin
      w_tbl_addr  = w_lk_idx;
      w_tbl_we    = 1'b0;
      w_tbl_wdata = NOT_TAKEN;
      if (w_busy) begin
         w_tbl_addr  = r_walk_cnt;
         w_tbl_we    = w_walk_en;
         w_tbl_wdata = INIT_PRED;
      end else if (w_up_acc) begin
         w_tbl_addr  = w_up_idx;
         w_tbl_we    = 1'b1;
         w_tbl_wdata = i_upd_result;
      end else begin
         w_tbl_addr  = w_lk_idx;
         w_tbl_we    = 1'b0;
         w_tbl_wdata = NOT_TAKEN;
      end
   end

   bp_table #(
      .IDX_W (IDX_W)
   ) u_table (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_addr  (w_tbl_addr),
      .i_we    (w_tbl_we),
      .i_wdata (w_tbl_wdata),
      .i_re    (w_lk_acc),
      .o_rdata (w_tbl_rdata)
   );

   // Prediction valid pulses the cycle after each accepted lookup.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pred_valid <= 1'b0;
      end else begin
         r_pred_valid <= w_lk_acc;
      end
   end

   assign o_pred_valid   = r_pred_valid;
   assign o_pred_taken   = w_tbl_rdata;
   assign o_lookup_ready = w_lookup_ready;
   assign o_upd_ready    = w_upd_ready;
   assign o_busy         = w_busy;

`ifdef BP_STATS_EN
   logic [31:0] r_stat_lookups;
   logic [31:0] r_stat_mispred;

   // Saturating statistics counters, cleared by reset and flush.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_stat_lookups <= 32'd0;
         r_stat_mispred <= 32'd0;
      end else begin
         if (w_lk_acc && (r_stat_lookups != 32'hFFFF_FFFF)) begin
            r_stat_lookups <= r_stat_lookups + 32'd1;
         end
         if (w_up_acc && (i_upd_pred != i_upd_result) &&
             (r_stat_mispred != 32'hFFFF_FFFF)) begin
            r_stat_mispred <= r_stat_mispred + 32'd1;
         end
      end
   end

   assign o_stat_lookups = r_stat_lookups;
   assign o_stat_mispred = r_stat_mispred;
`else
   logic w_unused_upd_pred;
   assign w_unused_upd_pred = i_upd_pred;
`endif

endmodule

// File: tb/tb_bp_table_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bp_table_ctrl
// Directed bench for bp_table_ctrl (IDX_W=6). Stimulus pushes the expected
// prediction of every accepted lookup into a queue; a monitor pops and
// compares whenever pred_valid is seen.
// ---------------------------------------------------------------------------
module tb_bp_table_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_en = 1'b1;
   logic        i_flush = 1'b0;
   logic        i_lookup_valid = 1'b0;
   logic [31:0] i_lookup_pc = 32'd0;
   logic        o_lookup_ready;
   logic        o_pred_valid;
   logic        o_pred_taken;
   logic        i_upd_valid = 1'b0;
   logic [31:0] i_upd_pc = 32'd0;
   logic        i_upd_result = 1'b0;
   logic        i_upd_pred = 1'b0;
   logic        o_upd_ready;
   logic        o_busy;
`ifdef BP_STATS_EN
   logic [31:0] o_stat_lookups;
   logic [31:0] o_stat_mispred;
`endif

   int   n_total = 0;
   int   n_pass  = 0;
   logic exp_q[$];

   always #5 i_clk = ~i_clk;

   bp_table_ctrl dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_en           (i_en),
      .i_flush        (i_flush),
      .i_lookup_valid (i_lookup_valid),
      .i_lookup_pc    (i_lookup_pc),
      .o_lookup_ready (o_lookup_ready),
      .o_pred_valid   (o_pred_valid),
      .o_pred_taken   (o_pred_taken),
      .i_upd_valid    (i_upd_valid),
      .i_upd_pc       (i_upd_pc),
      .i_upd_result   (i_upd_result),
      .i_upd_pred     (i_upd_pred),
      .o_upd_ready    (o_upd_ready),
      .o_busy         (o_busy)
`ifdef BP_STATS_EN
      ,
      .o_stat_lookups (o_stat_lookups),
      .o_stat_mispred (o_stat_mispred)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Scoreboard monitor: every pred_valid must match the oldest expectation.
   always @(negedge i_clk) begin
      if (o_pred_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL pred_unexpected: got pred_valid=1, expected no outstanding lookup");
         end else begin
            chk("pred_taken", {31'd0, o_pred_taken}, {31'd0, exp_q.pop_front()});
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic do_lookup(input logic [31:0] pc, input logic exp);
      int n = 0;
      i_lookup_valid = 1'b1;
      i_lookup_pc    = pc;
      @(negedge i_clk);
      while (!o_lookup_ready && n < 100) begin
         n++;
         @(negedge i_clk);
      end
      if (o_lookup_ready) exp_q.push_back(exp);
      else begin
         n_total++;
         $display("FAIL lookup_timeout: got no lookup_ready in 100 cycles, expected acceptance");
      end
      @(posedge i_clk); #1;
      i_lookup_valid = 1'b0;
   endtask

   task automatic do_update(input logic [31:0] pc, input logic res, input logic pred);
      int n = 0;
      i_upd_valid  = 1'b1;
      i_upd_pc     = pc;
      i_upd_result = res;
      i_upd_pred   = pred;
      @(negedge i_clk);
      while (!o_upd_ready && n < 100) begin
         n++;
         @(negedge i_clk);
      end
      if (!o_upd_ready) begin
         n_total++;
         $display("FAIL update_timeout: got no upd_ready in 100 cycles, expected acceptance");
      end
      @(posedge i_clk); #1;
      i_upd_valid = 1'b0;
   endtask

   // Called at a falling edge; counts busy cycles and any readies seen while
   // busy. en is dropped for 10 cycles starting at busy cycle en_off_at.
   task automatic count_busy(output int cyc, output int accs, input int en_off_at);
      cyc  = 0;
      accs = 0;
      while (o_busy && cyc < 500) begin
         cyc++;
         if (o_lookup_ready || o_upd_ready) accs++;
         if (en_off_at > 0 && cyc == en_off_at) i_en = 1'b0;
         if (en_off_at > 0 && cyc == en_off_at + 10) i_en = 1'b1;
         @(negedge i_clk);
      end
      i_en = 1'b1;
   endtask

   task automatic flush_pulse();
      i_flush = 1'b1;
      @(posedge i_clk); #1;
      i_flush = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      int accs;

      // Reset and init walk.
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("rst_busy", {31'd0, o_busy}, 32'd1);
      chk("rst_lookup_ready", {31'd0, o_lookup_ready}, 32'd0);
      chk("rst_upd_ready", {31'd0, o_upd_ready}, 32'd0);
      chk("rst_pred_valid", {31'd0, o_pred_valid}, 32'd0);
      chk("rst_pred_taken", {31'd0, o_pred_taken}, 32'd0);
`ifdef BP_STATS_EN
      chk("rst_stat_lookups", o_stat_lookups, 32'd0);
      chk("rst_stat_mispred", o_stat_mispred, 32'd0);
`endif
      count_busy(cyc, accs, 0);
      chk("init_busy_cycles", cyc, 32'd64);
      @(posedge i_clk); #1;
      do_lookup(32'h0000_1000, 1'b1);

      // Update then lookup, including an aliasing PC.
      do_update(32'h100, 1'b0, 1'b1);
      do_lookup(32'h100, 1'b0);
      do_lookup(32'h104, 1'b1);
      do_lookup(32'h200, 1'b0);

      // Continuous contention: U,U,L repeating.
      i_upd_valid    = 1'b1;
      i_upd_pc       = 32'h10;
      i_upd_result   = 1'b0;
      i_upd_pred     = 1'b0;
      i_lookup_valid = 1'b1;
      i_lookup_pc    = 32'h20;
      for (int i = 0; i < 9; i++) begin
         @(negedge i_clk);
         chk($sformatf("cont_upd_ready_%0d", i), {31'd0, o_upd_ready}, (i % 3 != 2) ? 32'd1 : 32'd0);
         chk($sformatf("cont_lookup_ready_%0d", i), {31'd0, o_lookup_ready}, (i % 3 == 2) ? 32'd1 : 32'd0);
         if (o_lookup_ready) exp_q.push_back(1'b1);
      end
      @(posedge i_clk); #1;
      i_upd_valid    = 1'b0;
      i_lookup_valid = 1'b0;

      // Flush mid-run right after a lookup: pending prediction still appears.
      do_update(32'h0, 1'b0, 1'b0);
      do_update(32'h4, 1'b0, 1'b0);
      do_update(32'h8, 1'b0, 1'b0);
      do_lookup(32'h4, 1'b0);
      i_flush        = 1'b1;
      i_lookup_valid = 1'b1;
      i_lookup_pc    = 32'h4;
      i_upd_valid    = 1'b1;
      i_upd_pc       = 32'h8;
      @(negedge i_clk);
      chk("flush_lookup_ready", {31'd0, o_lookup_ready}, 32'd0);
      chk("flush_upd_ready", {31'd0, o_upd_ready}, 32'd0);
      @(posedge i_clk); #1;
      i_flush = 1'b0;
      @(negedge i_clk);
      count_busy(cyc, accs, 0);
      i_lookup_valid = 1'b0;
      i_upd_valid    = 1'b0;
      chk("flush_busy_cycles", cyc, 32'd64);
      chk("flush_accepts_while_busy", accs, 32'd0);
      @(posedge i_clk); #1;
      do_lookup(32'h0, 1'b1);
      do_lookup(32'h4, 1'b1);
      do_lookup(32'h8, 1'b1);
      do_lookup(32'h10, 1'b1);
      do_lookup(32'h100, 1'b1);

      // en low during the walk stretches busy by 10 cycles.
      flush_pulse();
      @(negedge i_clk);
      count_busy(cyc, accs, 5);
      chk("en_walk_busy_cycles", cyc, 32'd74);
      @(posedge i_clk); #1;

      // en low during RUN: no acceptance, pred_valid drops, pred_taken holds.
      do_update(32'h8, 1'b0, 1'b0);
      do_lookup(32'h8, 1'b0);
      i_en           = 1'b0;
      i_lookup_valid = 1'b1;
      i_lookup_pc    = 32'h104;
      i_upd_valid    = 1'b1;
      i_upd_pc       = 32'h104;
      i_upd_result   = 1'b0;
      @(negedge i_clk);
      chk("en_low_lookup_ready", {31'd0, o_lookup_ready}, 32'd0);
      chk("en_low_upd_ready", {31'd0, o_upd_ready}, 32'd0);
      @(posedge i_clk); #1;
      @(negedge i_clk);
      chk("en_low_pred_valid", {31'd0, o_pred_valid}, 32'd0);
      chk("en_low_pred_taken_hold", {31'd0, o_pred_taken}, 32'd0);
      @(posedge i_clk); #1;
      i_en           = 1'b1;
      i_lookup_valid = 1'b0;
      i_upd_valid    = 1'b0;
      do_lookup(32'h104, 1'b1);

`ifdef BP_STATS_EN
      flush_pulse();
      @(negedge i_clk);
      count_busy(cyc, accs, 0);
      @(posedge i_clk); #1;
      chk("stat_lookups_after_flush", o_stat_lookups, 32'd0);
      chk("stat_mispred_after_flush", o_stat_mispred, 32'd0);
      for (int k = 0; k < 5; k++) do_lookup(32'(k * 4), 1'b1);
      do_update(32'h0, 1'b0, 1'b1);
      do_update(32'h4, 1'b1, 1'b1);
      do_update(32'h8, 1'b0, 1'b1);
      chk("stat_lookups", o_stat_lookups, 32'd5);
      chk("stat_mispred", o_stat_mispred, 32'd2);
      flush_pulse();
      chk("stat_lookups_cleared", o_stat_lookups, 32'd0);
      chk("stat_mispred_cleared", o_stat_mispred, 32'd0);
`endif

      repeat (3) @(negedge i_clk);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
